// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the EN/RW/MFC memory responder.
package mem_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/mem_responder_if.sv
// Processor-to-memory handshake bundle (initiator = master, memory = slave).
interface mem_responder_if
    import mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    // Handshake: the initiator raises EN with RW/addr/wdata stable on the sampling edge
    // and holds EN high until it sees MFC; it then drops EN, and MFC/err fall one edge later.
    logic              EN;
    logic              RW;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              MFC;
    logic              err;

    modport master (output EN, RW, addr, wdata, input rdata, MFC, err);
    modport slave  (input EN, RW, addr, wdata, output rdata, MFC, err);

endinterface

// File: rtl/mem_responder_array.sv
// Single-port synchronous RAM: registered read port, no reset on contents or read data.
module mem_array
    import mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: latches a request, waits WAIT_CYCLES, accesses the array, reports MFC.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus,
    output state_t          state_o
);

    localparam logic [3:0]      WAIT_L  = 4'(WAIT_CYCLES);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rw_q, rw_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              mfc_q, mfc_d;
    logic              err_q, err_d;
    logic              rzero_q, rzero_d;
    logic              mem_we, mem_re, oor;
    logic [DATA_W-1:0] mem_rdata;

    assign oor = ({1'b0, addr_q} >= DEPTH_L);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            rw_q    <= RW_WRITE;
            wdata_q <= '0;
            mfc_q   <= 1'b0;
            err_q   <= 1'b0;
            rzero_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            wdata_q <= wdata_d;
            mfc_q   <= mfc_d;
            err_q   <= err_d;
            rzero_q <= rzero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rzero_d = rzero_q;
        mfc_d   = 1'b0;
        mem_we  = 1'b0;
        mem_re  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                err_d = 1'b0;
                if (bus.EN) begin
                    addr_d  = bus.addr;
                    rw_d    = bus.RW;
                    wdata_d = bus.wdata;
                    cnt_d   = WAIT_L;
                    state_d = (WAIT_L != 4'd0) ? ST_WAIT : ST_ACCESS;
                end
            end
            ST_WAIT: begin
                if (!bus.EN) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // Out-of-range reads force rdata to zero instead of touching the array.
                mem_we  = (rw_q == RW_WRITE) && !oor;
                mem_re  = (rw_q == RW_READ) && !oor;
                if (rw_q == RW_READ) rzero_d = oor;
                err_d   = oor;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                // MFC is registered from DONE, so it lags DONE entry by one edge.
                if (bus.EN) begin
                    mfc_d = 1'b1;
                end else begin
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk     (clk),
        .we_i    (mem_we),
        .re_i    (mem_re),
        .addr_i  (addr_q),
        .wdata_i (wdata_q),
        .rdata_o (mem_rdata)
    );

    assign bus.rdata = rzero_q ? '0 : mem_rdata;
    assign bus.MFC   = mfc_q;
    assign bus.err   = err_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: DUT A (2 wait states, 200 words) and DUT B (zero wait, 256 words).
module tb_mem_responder;
    import mem_pkg::*;

    logic clk, rst;
    logic en, rw, sel;
    logic [7:0]  addr;
    logic [15:0] wdata;
    int checks = 0;
    int errors = 0;

    mem_responder_if #(.ADDR_W(8), .DATA_W(16)) bus_a ();
    mem_responder_if #(.ADDR_W(8), .DATA_W(16)) bus_b ();
    state_t st_a, st_b;

    assign bus_a.EN    = en && !sel;
    assign bus_b.EN    = en && sel;
    assign bus_a.RW    = rw;
    assign bus_b.RW    = rw;
    assign bus_a.addr  = addr;
    assign bus_b.addr  = addr;
    assign bus_a.wdata = wdata;
    assign bus_b.wdata = wdata;

    logic        mfc_s, err_s;
    logic [15:0] rdata_s;
    state_t      st_s;
    assign mfc_s   = sel ? bus_b.MFC   : bus_a.MFC;
    assign err_s   = sel ? bus_b.err   : bus_a.err;
    assign rdata_s = sel ? bus_b.rdata : bus_a.rdata;
    assign st_s    = sel ? st_b : st_a;

    mem_responder #(.ADDR_W(8), .DATA_W(16), .DEPTH(200), .WAIT_CYCLES(2)) dut_a (
        .clk (clk), .rst (rst), .bus (bus_a), .state_o (st_a));
    mem_responder #(.ADDR_W(8), .DATA_W(16), .DEPTH(256), .WAIT_CYCLES(0)) dut_b (
        .clk (clk), .rst (rst), .bus (bus_b), .state_o (st_b));

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One full handshake; inputs are scrambled after the sampling edge to prove latching.
    task automatic do_op(input string tag, input logic s, input logic r, input logic [7:0] a,
                         input logic [15:0] d, input int exp_lat, input logic [15:0] exp_rd,
                         input logic exp_err);
        int k;
        bit seen;
        @(negedge clk);
        sel = s; rw = r; addr = a; wdata = d; en = 1'b1;
        @(posedge clk);
        #1;
        rw = ~r; addr = ~a; wdata = ~d;
        k = 0;
        seen = 1'b0;
        while (!seen && k < 20) begin
            @(posedge clk);
            k++;
            #1;
            if (mfc_s) seen = 1'b1;
        end
        check({tag, " mfc_latency"}, k, exp_lat);
        check({tag, " rdata"}, rdata_s, exp_rd);
        check({tag, " err"}, err_s, exp_err);
        @(negedge clk);
        check({tag, " rdata_stable"}, rdata_s, exp_rd);
        en = 1'b0;
        @(posedge clk);
        #1;
        check({tag, " mfc_fall"}, mfc_s, 1'b0);
        check({tag, " err_clear"}, err_s, 1'b0);
        check({tag, " idle_after"}, 32'(st_s), 32'(ST_IDLE));
    endtask

    typedef struct {
        logic        rw;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int seen_mfc;
        vecs[0]  = '{RW_WRITE, 8'h10, 16'hBEEF, 16'h0000, 1'b0};
        vecs[1]  = '{RW_READ,  8'h10, 16'h0000, 16'hBEEF, 1'b0};
        vecs[2]  = '{RW_WRITE, 8'h20, 16'h1111, 16'hBEEF, 1'b0};
        vecs[3]  = '{RW_WRITE, 8'h05, 16'h0ABC, 16'hBEEF, 1'b0};
        vecs[4]  = '{RW_WRITE, 8'h70, 16'h7070, 16'hBEEF, 1'b0};
        vecs[5]  = '{RW_WRITE, 8'hC7, 16'hCAFE, 16'hBEEF, 1'b0};
        vecs[6]  = '{RW_WRITE, 8'h00, 16'hA000, 16'hBEEF, 1'b0};
        vecs[7]  = '{RW_WRITE, 8'h01, 16'hA001, 16'hBEEF, 1'b0};
        vecs[8]  = '{RW_WRITE, 8'h02, 16'hA002, 16'hBEEF, 1'b0};
        vecs[9]  = '{RW_READ,  8'hC7, 16'h0000, 16'hCAFE, 1'b0};
        vecs[10] = '{RW_READ,  8'hC8, 16'h0000, 16'h0000, 1'b1};
        vecs[11] = '{RW_READ,  8'hF0, 16'h0000, 16'h0000, 1'b1};
        vecs[12] = '{RW_WRITE, 8'hF0, 16'h5555, 16'h0000, 1'b1};
        vecs[13] = '{RW_READ,  8'h70, 16'h0000, 16'h7070, 1'b0};

        rst = 1'b1; en = 1'b0; sel = 1'b0; rw = RW_READ; addr = '0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_a mfc", mfc_s, 1'b0);
        check("rst_a err", err_s, 1'b0);
        check("rst_a rdata", rdata_s, 16'h0000);
        check("rst_a state", 32'(st_s), 32'(ST_IDLE));
        sel = 1'b1;
        #1;
        check("rst_b mfc", mfc_s, 1'b0);
        check("rst_b rdata", rdata_s, 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++)
            do_op($sformatf("vec%0d", i), 1'b0, vecs[i].rw, vecs[i].addr, vecs[i].wdata, 4,
                  vecs[i].exp_rdata, vecs[i].exp_err);

        // Abort: EN high for just the sampling edge, then dropped while in WAIT.
        @(negedge clk);
        sel = 1'b0; rw = RW_WRITE; addr = 8'h20; wdata = 16'hAAAA; en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        seen_mfc = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (mfc_s) seen_mfc++;
        end
        check("abort mfc_never", seen_mfc, 0);
        check("abort rdata_kept", rdata_s, 16'h7070);
        check("abort state", 32'(st_s), 32'(ST_IDLE));
        do_op("abort_readback", 1'b0, RW_READ, 8'h20, 16'h0000, 4, 16'h1111, 1'b0);

        // Reset while a write sits in WAIT.
        @(negedge clk);
        sel = 1'b0; rw = RW_WRITE; addr = 8'h05; wdata = 16'h7777; en = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_mid mfc", mfc_s, 1'b0);
        check("rst_mid err", err_s, 1'b0);
        check("rst_mid rdata", rdata_s, 16'h0000);
        check("rst_mid state", 32'(st_s), 32'(ST_IDLE));
        @(negedge clk);
        en = 1'b0;
        rst = 1'b0;
        do_op("rst_readback", 1'b0, RW_READ, 8'h05, 16'h0000, 4, 16'h0ABC, 1'b0);

        // Fetch-style back-to-back reads of consecutive words.
        do_op("fetch0", 1'b0, RW_READ, 8'h00, 16'h0000, 4, 16'hA000, 1'b0);
        do_op("fetch1", 1'b0, RW_READ, 8'h01, 16'h0000, 4, 16'hA001, 1'b0);
        do_op("fetch2", 1'b0, RW_READ, 8'h02, 16'h0000, 4, 16'hA002, 1'b0);

        // Zero wait states on DUT B, including the top address of a full-depth array.
        do_op("w0_wr00", 1'b1, RW_WRITE, 8'h00, 16'h1234, 2, 16'h0000, 1'b0);
        do_op("w0_rd00", 1'b1, RW_READ,  8'h00, 16'h0000, 2, 16'h1234, 1'b0);
        do_op("w0_wrFF", 1'b1, RW_WRITE, 8'hFF, 16'h00FF, 2, 16'h1234, 1'b0);
        do_op("w0_rdFF", 1'b1, RW_READ,  8'hFF, 16'h0000, 2, 16'h00FF, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
